// File: rtl/tpic_readback.sv
// Readback engine for the TPIC relay-driver chain: re-shifts a commanded image
// through the chain without pulsing RCK and compares what falls out of TPIC.SO.
module tpic_readback #(
    parameter int WIDTH   = 432,
    parameter int CLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             tpic_miso_i,
    output logic             sclk_o,
    output logic             sout_o,
    output logic             rck_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] readback_o,
    output logic             mismatch_o,
    output logic [15:0]      error_count_o
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [DW-1:0]    divCnt_q, divCnt_d;
    logic [BW-1:0]    bitCnt_q, bitCnt_d;
    logic [WIDTH-1:0] shiftReg_q, shiftReg_d;
    logic [WIDTH-1:0] readback_q, readback_d;
    logic [15:0]      errCount_q, errCount_d;
    logic             mismatch_q, mismatch_d;
    logic             done_q, done_d;
    logic [BW-1:0]    capIdx;

    // The shift register doubles as the snapshot: its MSB is always the
    // commanded bit that belongs to the capture currently in progress.
    assign capIdx = LAST_BIT - bitCnt_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= IDLE;
            divCnt_q   <= '0;
            bitCnt_q   <= '0;
            shiftReg_q <= '0;
            readback_q <= '0;
            errCount_q <= '0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            divCnt_q   <= divCnt_d;
            bitCnt_q   <= bitCnt_d;
            shiftReg_q <= shiftReg_d;
            readback_q <= readback_d;
            errCount_q <= errCount_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        divCnt_d   = divCnt_q;
        bitCnt_d   = bitCnt_q;
        shiftReg_d = shiftReg_q;
        readback_d = readback_q;
        errCount_d = errCount_q;
        mismatch_d = mismatch_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d    = LOAD;
                    shiftReg_d = data_i;
                    bitCnt_d   = '0;
                    divCnt_d   = '0;
                    errCount_d = '0;
                    mismatch_d = 1'b0;
                end
            end
            LOAD: begin
                state_d  = SHIFT_LO;
                divCnt_d = '0;
            end
            SHIFT_LO: begin
                if (divCnt_q == LAST_DIV) begin
                    // sclk rises on this edge; tpic_miso still holds the pre-edge bit.
                    state_d             = SHIFT_HI;
                    divCnt_d            = '0;
                    readback_d[capIdx]  = tpic_miso_i;
                    if ((tpic_miso_i != shiftReg_q[WIDTH-1]) && (errCount_q != 16'hFFFF))
                        errCount_d = errCount_q + 16'd1;
                end else begin
                    divCnt_d = divCnt_q + DW'(1);
                end
            end
            SHIFT_HI: begin
                if (divCnt_q == LAST_DIV) begin
                    divCnt_d = '0;
                    if (bitCnt_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        state_d    = SHIFT_LO;
                        bitCnt_d   = bitCnt_q + BW'(1);
                        shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    divCnt_d = divCnt_q + DW'(1);
                end
            end
            DONE: begin
                state_d    = IDLE;
                mismatch_d = (errCount_q != 16'd0);
                done_d     = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    assign sclk_o        = (state_q == SHIFT_HI);
    assign sout_o        = ((state_q == LOAD) || (state_q == SHIFT_LO) || (state_q == SHIFT_HI))
                           ? shiftReg_q[WIDTH-1] : 1'b0;
    assign rck_o         = 1'b0;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign readback_o    = readback_q;
    assign mismatch_o    = mismatch_q;
    assign error_count_o = errCount_q;

endmodule

// File: tb/tb_tpic_readback.sv
// Bench for tpic_readback with a 16-bit chain model: directed vector table,
// randomized runs against a popcount reference, and multi-cycle corner sequences.
module tb_tpic_readback;

    localparam int W   = 16;
    localparam int DIV = 2;
    localparam int RUN_CYCLES = 2 * DIV * W + 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  data = '0;
    logic          tpic_miso;
    logic          sclk, sout, rck, busy, done, mismatch;
    logic [W-1:0]  readback;
    logic [15:0]   error_count;

    logic [W-1:0]  chain;
    logic [W-1:0]  preloadVal = '0;
    logic          loadChain = 1'b0;
    int            sclkRises = 0;
    bit            rckSeen = 1'b0;
    bit            startPending = 1'b0;
    int            checks = 0;
    int            errors = 0;

    typedef struct {
        bit           doPreload;
        logic [W-1:0] preload;
        logic [W-1:0] data;
        logic [W-1:0] expRb;
        logic [15:0]  expErr;
        logic         expMis;
    } vec_t;

    vec_t vecs[4];

    tpic_readback #(.WIDTH(W), .CLK_DIV(DIV)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .start_i       (start),
        .data_i        (data),
        .tpic_miso_i   (tpic_miso),
        .sclk_o        (sclk),
        .sout_o        (sout),
        .rck_o         (rck),
        .busy_o        (busy),
        .done_o        (done),
        .readback_o    (readback),
        .mismatch_o    (mismatch),
        .error_count_o (error_count)
    );

    always #5 clk = ~clk;

    // Chain model: SO is the MSB, SI shifts in at the LSB on each sclk rise.
    assign tpic_miso = chain[W-1];
    always @(posedge sclk or posedge loadChain) begin
        if (loadChain) chain <= preloadVal;
        else           chain <= {chain[W-2:0], sout};
    end

    always @(posedge sclk) sclkRises++;
    always @(posedge clk) if (rck !== 1'b0) rckSeen = 1'b1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic preloadChain(input logic [W-1:0] v);
        preloadVal = v;
        loadChain  = 1'b1;
        #1 loadChain = 1'b0;
    endtask

    // Issues a start (unless one is already pending from a done cycle) and
    // follows the run to completion, measuring busy length and sclk rises.
    task automatic applyStimulus(input logic [W-1:0] d, input bit extra, input bit chainNext,
                                 input logic [W-1:0] nextD, output int busyCycles,
                                 output int rises, output logic doneSeen, output logic doneAfter);
        int base;
        if (!startPending) begin
            @(negedge clk);
            data  = d;
            start = 1'b1;
        end
        base = sclkRises;
        @(negedge clk);
        start = 1'b0;
        startPending = 1'b0;
        busyCycles = 0;
        while (busy && busyCycles < 200) begin
            busyCycles++;
            start = extra && (busyCycles == 10 || busyCycles == 40);
            if (extra && busyCycles == 20) data = 16'h1234;
            @(negedge clk);
        end
        start = 1'b0;
        doneSeen = done;
        if (chainNext) begin
            data = nextD;
            start = 1'b1;
            startPending = 1'b1;
            doneAfter = 1'b0;
        end else begin
            @(negedge clk);
            doneAfter = done;
        end
        rises = sclkRises - base;
    endtask

    task automatic checkRun(input string tag, input logic [W-1:0] pre, input logic [W-1:0] d,
                            input int busyCycles, input int rises, input logic doneSeen,
                            input logic doneAfter, input bit checkDoneLow);
        logic [15:0] expErr;
        expErr = 16'($countones(pre ^ d));
        checkOutput({tag, " busy_cycles"}, 32'(busyCycles), 32'(RUN_CYCLES));
        checkOutput({tag, " sclk_rises"}, 32'(rises), 32'(W));
        checkOutput({tag, " done_pulse"}, 32'(doneSeen), 32'd1);
        if (checkDoneLow) checkOutput({tag, " done_low"}, 32'(doneAfter), 32'd0);
        checkOutput({tag, " readback"}, 32'(readback), 32'(pre));
        checkOutput({tag, " error_count"}, 32'(error_count), 32'(expErr));
        checkOutput({tag, " mismatch"}, 32'(mismatch), 32'(pre != d));
        checkOutput({tag, " chain_after"}, 32'(chain), 32'(d));
    endtask

    initial begin
        int bc, rs;
        logic ds, da;
        logic [W-1:0] pre, d;
        int waitCnt;

        vecs[0] = '{1'b1, 16'hA5C3, 16'hA5C3, 16'hA5C3, 16'd0,  1'b0};
        vecs[1] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'd16, 1'b1};
        vecs[2] = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 16'd1,  1'b1};
        vecs[3] = '{1'b0, 16'h0000, 16'h0000, 16'h0000, 16'd0,  1'b0};

        preloadChain(16'h0000);
        #12;
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset sclk", 32'(sclk), 32'd0);
        checkOutput("reset sout", 32'(sout), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset readback", 32'(readback), 32'd0);
        checkOutput("reset error_count", 32'(error_count), 32'd0);
        checkOutput("reset mismatch", 32'(mismatch), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (vecs[i].doPreload) preloadChain(vecs[i].preload);
            applyStimulus(vecs[i].data, 1'b0, 1'b0, '0, bc, rs, ds, da);
            checkRun($sformatf("vec%0d", i), vecs[i].preload, vecs[i].data, bc, rs, ds, da, 1'b1);
            checkOutput($sformatf("vec%0d table_rb", i), 32'(readback), 32'(vecs[i].expRb));
            checkOutput($sformatf("vec%0d table_err", i), 32'(error_count), 32'(vecs[i].expErr));
            checkOutput($sformatf("vec%0d table_mis", i), 32'(mismatch), 32'(vecs[i].expMis));
        end

        for (int i = 0; i < 20; i++) begin
            pre = 16'($urandom);
            d   = (i % 4 == 0) ? pre : 16'($urandom);
            @(negedge clk);
            preloadChain(pre);
            applyStimulus(d, 1'b0, 1'b0, '0, bc, rs, ds, da);
            checkRun($sformatf("rand%0d", i), pre, d, bc, rs, ds, da, 1'b1);
        end

        // Restart attempts and data changes mid-run must be ignored.
        @(negedge clk);
        preloadChain(16'h5A5A);
        applyStimulus(16'h0F0F, 1'b1, 1'b0, '0, bc, rs, ds, da);
        checkRun("midrun", 16'h5A5A, 16'h0F0F, bc, rs, ds, da, 1'b1);
        checkOutput("midrun no_restart", 32'(busy), 32'd0);

        // Reset asserted on the 7th sclk rise of a run.
        @(negedge clk);
        preloadChain(16'hFFFF);
        @(negedge clk);
        data  = 16'h0000;
        start = 1'b1;
        waitCnt = sclkRises;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 200 && sclkRises < waitCnt + 7; c++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst7 rises_reached", 32'(sclkRises - waitCnt), 32'd7);
        reset_n = 1'b0;
        #1;
        checkOutput("rst7 sclk", 32'(sclk), 32'd0);
        checkOutput("rst7 sout", 32'(sout), 32'd0);
        checkOutput("rst7 busy", 32'(busy), 32'd0);
        checkOutput("rst7 readback", 32'(readback), 32'd0);
        checkOutput("rst7 error_count", 32'(error_count), 32'd0);
        checkOutput("rst7 mismatch", 32'(mismatch), 32'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst7 no_resume", 32'(busy), 32'd0);
        reset_n = 1'b1;
        preloadChain(16'h3C96);
        applyStimulus(16'hC369, 1'b0, 1'b0, '0, bc, rs, ds, da);
        checkRun("post_rst", 16'h3C96, 16'hC369, bc, rs, ds, da, 1'b1);

        // Start coincident with done: the second run follows back to back.
        @(negedge clk);
        preloadChain(16'h1111);
        applyStimulus(16'h2222, 1'b0, 1'b1, 16'h7777, bc, rs, ds, da);
        checkRun("done_start1", 16'h1111, 16'h2222, bc, rs, ds, da, 1'b0);
        applyStimulus(16'h7777, 1'b0, 1'b0, '0, bc, rs, ds, da);
        checkRun("done_start2", 16'h2222, 16'h7777, bc, rs, ds, da, 1'b1);

        checkOutput("rck never high", 32'(rckSeen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tpic_readback.md
Name: tpic_readback

Overview:
- Readback engine for the TPIC relay-driver daisy chain. It is the receiving end of the TPIC serial path that mem2tpic drives.
- On request it re-shifts a commanded WIDTH-bit image into the chain and captures the chain's serial output (TPIC.SO) into a readback register. It does not pulse RCK, so relay outputs never change.
- It reports the captured image, a mismatch flag and a bit-error count against the commanded image.
- Sits beside mem2tpic; top-level arbitration gives it the tpic_* lines while busy.

Parameters:
- WIDTH, 432, chain length in bits (equals memory width).
- CLK_DIV, 2, system clocks per sclk half-period (>=1).

Ports:
- clk  in  1  system clock, 50MHz.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request, sampled in IDLE only.
- data  in  WIDTH  commanded image; snapshotted on accepted start.
- tpic_miso  in  1  chain serial output (TPIC.SO).
- sclk  out  1  shift clock to chain.
- sout  out  1  serial data to chain (TPIC.SI).
- rck  out  1  storage clock; constant 0.
- busy  out  1  high while a readback cycle is in progress.
- done  out  1  one-cycle completion pulse.
- readback  out  WIDTH  captured chain contents.
- mismatch  out  1  readback != snapshot.
- error_count  out  16  number of differing bits.

Behaviour:
- Reset (async, reset_n=0): state IDLE, sclk=0, sout=0, rck=0, busy=0, done=0, readback=0, mismatch=0, error_count=0, snapshot and counters cleared. Applies immediately, including mid-shift. There is no resume after reset.
- IDLE, start=1: next cycle enters LOAD.
  - snapshot<=data, shift register<=data, bit counter<=0, error_count<=0.
  - busy<=1, sout<=data[WIDTH-1], sclk=0.
- LOAD (1 cycle) then SHIFT_LO: sclk=0 for CLK_DIV cycles with sout stable.
- SHIFT_LO -> SHIFT_HI: sclk=1 for CLK_DIV cycles.
  - On the clock edge where sclk rises, tpic_miso is sampled as its pre-edge value.
  - Capture bit i (i=0 first) goes to readback[WIDTH-1-i], MSB first.
  - If the captured bit != snapshot[WIDTH-1-i], error_count increments.
- SHIFT_HI end: if bit counter = WIDTH-1, go to DONE with sclk=0. Otherwise increment the counter, shift the register left, present the next sout bit and return to SHIFT_LO.
- DONE (1 cycle): sclk=0, sout=0.
  - mismatch<=(error_count!=0).
  - Next cycle: IDLE, busy=0, done=1 for exactly that one cycle.
- Timing:
  - busy is high for exactly 2*CLK_DIV*WIDTH+2 cycles.
  - Exactly WIDTH sclk rising edges per run.
  - Shifted-in data equals the shifted-out image, so the chain shift register holds data afterwards.
- Results: readback, mismatch and error_count hold from done until the next accepted start.
  - Bits not yet captured keep their previous value until overwritten.
  - mismatch is cleared at start.
- Ignored inputs:
  - start while busy (no restart, no extension).
  - Changes on data while busy (snapshot used).
  - start coincident with the done cycle is accepted: done=1 and the next cycle is LOAD.
- error_count saturates at 16'hFFFF. This is unreachable for WIDTH<65536, but required.
- rck is tied 0 in all states; storage registers and relay outputs are never updated by this block.

Test Plan:
- WIDTH=16, CLK_DIV=2, bench 16-bit shift-register chain model preloaded 16'hA5C3, data=16'hA5C3, start -> busy 66 cycles, 16 sclk rises, done 1 cycle, readback=16'hA5C3, mismatch=0, error_count=0, rck never 1.
- Chain preloaded 16'h0000, data=16'hFFFF -> readback=16'h0000, mismatch=1, error_count=16, chain model then holds 16'hFFFF.
- Chain preloaded 16'h8000, data=16'h0000 -> readback=16'h8000, error_count=1.
  - Immediate second start with data=16'h0000 -> readback=16'h0000, error_count=0, mismatch=0.
- start pulsed again at cycle 10 and cycle 40 of a run, data changed to 16'h1234 mid-run -> single run of 66 cycles, compare uses original snapshot, exactly 16 sclk rises.
- reset_n=0 at sclk rise 7 -> same cycle sclk=0, sout=0, busy=0, all results 0. After release, new start gives a full 66-cycle run.
- start asserted in the done cycle -> done=1 that cycle, busy=1 next cycle, second run completes normally.
